// File: rtl/serial_frame_tx.sv
// -----------------------------------------------------------------------------
// serial_frame_tx
//
// Serialises a WIDTH-bit payload onto a single registered output, MSB first.
// A frame is requested with a start pulse while idle. The payload is captured
// on the accepting edge, so later changes on data never disturb a frame that
// is already in flight. Start is ignored while a frame is in progress, and no
// request is queued.
//
// Build option:
//   SERIAL_FRAME_TX_PREAMBLE_EN  When defined, every frame is preceded by the
//                                preamble 1,0,1. Busy then lasts WIDTH+3
//                                cycles. When undefined, the PRE state and
//                                its counter are not built, and busy lasts
//                                WIDTH cycles.
//
// Parameters:
//   WIDTH   payload bits per frame (legal range 2..32)
//
// Ports:
//   clk     single clock; all state updates on its rising edge
//   reset   synchronous, active-high; aborts any frame without a done pulse
//   start   frame request, sampled only in IDLE
//   data    payload, captured when start is accepted
//   x       registered serial bit stream
//   busy    high while a frame is being shifted out
//   done    one-cycle pulse in the cycle after the last frame bit
// -----------------------------------------------------------------------------
module serial_frame_tx #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] data,
   output logic             x,
   output logic             busy,
   output logic             done
);

   // The counter must hold the value WIDTH itself, so it gets one spare code.
   localparam int            CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH);

   localparam logic [1:0] IDLE = 2'd0;
`ifdef SERIAL_FRAME_TX_PREAMBLE_EN
   localparam logic [1:0] PRE  = 2'd1;
`endif
   localparam logic [1:0] DATA = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]       state;
   logic [WIDTH-1:0] shift;
   logic [CW-1:0]    cnt;    // number of payload bits already placed on x
`ifdef SERIAL_FRAME_TX_PREAMBLE_EN
   logic [1:0]       pre_cnt; // index of the preamble bit currently on x
`endif

   // NOTE: every register here, including the shift register, is cleared by
   // reset; all state is updated with non-blocking assignments, so the case
   // arms below read the values from before this edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         shift   <= '0;
         cnt     <= '0;
         x       <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
`ifdef SERIAL_FRAME_TX_PREAMBLE_EN
         pre_cnt <= 2'd0;
`endif
      end else begin
         case (state)
            IDLE: begin
               x    <= 1'b0;
               busy <= 1'b0;
               done <= 1'b0;
               if (start) begin
                  busy <= 1'b1;
`ifdef SERIAL_FRAME_TX_PREAMBLE_EN
                  // First preamble bit goes out in the cycle after acceptance.
                  state   <= PRE;
                  shift   <= data;
                  x       <= 1'b1;
                  pre_cnt <= 2'd0;
`else
                  // The payload MSB goes straight out. It counts as bit 1.
                  state <= DATA;
                  x     <= data[WIDTH-1];
                  shift <= data << 1;
                  cnt   <= CW'(1);
`endif
               end
            end

`ifdef SERIAL_FRAME_TX_PREAMBLE_EN
            PRE: begin
               case (pre_cnt)
                  2'd0: begin
                     x       <= 1'b0;
                     pre_cnt <= 2'd1;
                  end
                  2'd1: begin
                     x       <= 1'b1;
                     pre_cnt <= 2'd2;
                  end
                  default: begin
                     // The last preamble bit is on x. Launch the payload MSB.
                     state   <= DATA;
                     x       <= shift[WIDTH-1];
                     shift   <= shift << 1;
                     cnt     <= CW'(1);
                     pre_cnt <= 2'd0;
                  end
               endcase
            end
`endif

            DATA: begin
               if (cnt == LAST) begin
                  state <= DONE;
                  x     <= 1'b0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  cnt   <= '0;
               end else begin
                  x     <= shift[WIDTH-1];
                  shift <= shift << 1;
                  cnt   <= cnt + 1'b1;
               end
            end

            DONE: begin
               state <= IDLE;
               x     <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b0;
            end

            default: begin
               state <= IDLE;
               x     <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_tx
//
// Self-checking bench for serial_frame_tx. It uses a WIDTH=8 instance and a
// WIDTH=4 instance. Expected {x,busy,done} triples are queued per cycle when a
// frame is requested. They are popped and compared, one per clock, in the
// cycle after each rising edge. Preamble expectations follow
// SERIAL_FRAME_TX_PREAMBLE_EN.
// -----------------------------------------------------------------------------
module tb_serial_frame_tx;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start8 = 1'b0;
   logic [7:0] data8 = 8'h00;
   logic       x8, busy8, done8;
   logic       start4 = 1'b0;
   logic [3:0] data4 = 4'h0;
   logic       x4, busy4, done4;

   always #5 clk = ~clk;

   serial_frame_tx #(.WIDTH(8)) dut8 (
      .clk  (clk),
      .reset(reset),
      .start(start8),
      .data (data8),
      .x    (x8),
      .busy (busy8),
      .done (done8)
   );

   serial_frame_tx #(.WIDTH(4)) dut4 (
      .clk  (clk),
      .reset(reset),
      .start(start4),
      .data (data4),
      .x    (x4),
      .busy (busy4),
      .done (done4)
   );

`ifdef SERIAL_FRAME_TX_PREAMBLE_EN
   localparam bit PRE_EN = 1'b1;
`else
   localparam bit PRE_EN = 1'b0;
`endif

   typedef struct packed {
      logic x;
      logic busy;
      logic done;
   } exp_t;

   exp_t sb[$];
   int   tests_run    = 0;
   int   tests_failed = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t mk(logic xv, logic bv, logic dv);
      exp_t e;
      e.x    = xv;
      e.busy = bv;
      e.done = dv;
      return e;
   endfunction

   // Queue the expected frame: optional 101 preamble, payload MSB first, done.
   function automatic void push_frame(int w, logic [31:0] d);
      if (PRE_EN) begin
         sb.push_back(mk(1'b1, 1'b1, 1'b0));
         sb.push_back(mk(1'b0, 1'b1, 1'b0));
         sb.push_back(mk(1'b1, 1'b1, 1'b0));
      end
      for (int i = w - 1; i >= 0; i--) sb.push_back(mk(d[i], 1'b1, 1'b0));
      sb.push_back(mk(1'b0, 1'b0, 1'b1));
   endfunction

   function automatic void push_idle(int n);
      for (int i = 0; i < n; i++) sb.push_back(mk(1'b0, 1'b0, 1'b0));
   endfunction

   // Reset wins over start, and start is then taken at the first free edge.
   task automatic test_reset();
      exp_t e;
      int   n = 0;
      reset  = 1'b1;
      start8 = 1'b1;
      data8  = 8'h5A;
      start4 = 1'b1;
      data4  = 4'hF;
      step();
      step();
      tests_run++;
      if ({x8, busy8, done8} !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_out8: got %b%b%b required 000", x8, busy8, done8);
      end
      tests_run++;
      if ({x4, busy4, done4} !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_out4: got %b%b%b required 000", x4, busy4, done4);
      end
      start4 = 1'b0;
      reset  = 1'b0;
      push_frame(8, 32'h5A);
      push_idle(2);
      while (sb.size() > 0) begin
         step();
         e = sb.pop_front();
         tests_run++;
         if ({x8, busy8, done8} !== e) begin
            tests_failed++;
            $display("FAIL first_edge_frame cycle %0d: got %b%b%b required %b",
                     n, x8, busy8, done8, e);
         end
         if (n == 0) start8 = 1'b0;
         n++;
      end
   endtask

   task automatic test_basic();
      exp_t e;
      int   n = 0;
      start8 = 1'b1;
      data8  = 8'hA5;
      push_frame(8, 32'hA5);
      push_idle(2);
      while (sb.size() > 0) begin
         step();
         e = sb.pop_front();
         tests_run++;
         if ({x8, busy8, done8} !== e) begin
            tests_failed++;
            $display("FAIL frame_a5 cycle %0d: got %b%b%b required %b",
                     n, x8, busy8, done8, e);
         end
         if (n == 0) start8 = 1'b0;
         n++;
      end
   endtask

   // Frame 3C plus a 101 detector on x that must fire on the last preamble bit.
   task automatic test_preamble();
      exp_t       e;
      logic [2:0] hist = 3'b000;
      int         n = 0;
      start8 = 1'b1;
      data8  = 8'h3C;
      push_frame(8, 32'h3C);
      push_idle(2);
      while (sb.size() > 0) begin
         step();
         hist = {hist[1:0], x8};
         e = sb.pop_front();
         tests_run++;
         if ({x8, busy8, done8} !== e) begin
            tests_failed++;
            $display("FAIL frame_3c cycle %0d: got %b%b%b required %b",
                     n, x8, busy8, done8, e);
         end
         if (n == 2) begin
            tests_run++;
            if ((hist == 3'b101) !== PRE_EN) begin
               tests_failed++;
               $display("FAIL det101 cycle 2: got %b required %b",
                        (hist == 3'b101), PRE_EN);
            end
         end
         if (n == 0) start8 = 1'b0;
         n++;
      end
   endtask

   // Reset mid-frame aborts it with no done pulse; a new frame then runs fully.
   task automatic test_abort();
      exp_t e;
      int   n = 0;
      start8 = 1'b1;
      data8  = 8'hC3;
      push_frame(8, 32'hC3);
      for (int i = 0; i < 3; i++) begin
         step();
         e = sb.pop_front();
         tests_run++;
         if ({x8, busy8, done8} !== e) begin
            tests_failed++;
            $display("FAIL abort_pre cycle %0d: got %b%b%b required %b",
                     i, x8, busy8, done8, e);
         end
         start8 = 1'b0;
      end
      sb.delete();
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if ({x8, busy8, done8} !== 3'b000) begin
            tests_failed++;
            $display("FAIL abort_quiet cycle %0d: got %b%b%b required 000",
                     i, x8, busy8, done8);
         end
         if (i < 3) step();
      end
      start8 = 1'b1;
      data8  = 8'h96;
      push_frame(8, 32'h96);
      push_idle(2);
      while (sb.size() > 0) begin
         step();
         e = sb.pop_front();
         tests_run++;
         if ({x8, busy8, done8} !== e) begin
            tests_failed++;
            $display("FAIL after_abort cycle %0d: got %b%b%b required %b",
                     n, x8, busy8, done8, e);
         end
         if (n == 0) start8 = 1'b0;
         n++;
      end
   endtask

   // Start pulses in mid-frame and in DONE are dropped; data changes are ignored.
   task automatic test_ignore_start();
      exp_t e;
      int   n = 0;
      int   done_idx = (PRE_EN ? 3 : 0) + 8;
      start8 = 1'b1;
      data8  = 8'h4E;
      push_frame(8, 32'h4E);
      push_idle(3);
      while (sb.size() > 0) begin
         step();
         e = sb.pop_front();
         tests_run++;
         if ({x8, busy8, done8} !== e) begin
            tests_failed++;
            $display("FAIL ignore_start cycle %0d: got %b%b%b required %b",
                     n, x8, busy8, done8, e);
         end
         if (n == 0) start8 = 1'b0;
         if (n == 2) begin
            start8 = 1'b1;
            data8  = 8'hFF;
         end
         if (n == 3) start8 = 1'b0;
         if (n == 5) data8 = 8'h00;
         if (n == done_idx) start8 = 1'b1;
         if (n == done_idx + 1) start8 = 1'b0;
         n++;
      end
   endtask

   // Start held high: frames repeat with one DONE and one IDLE cycle between.
   task automatic test_back_to_back();
      exp_t e;
      int   n = 0;
      for (int f = 0; f < 3; f++) begin
         push_frame(8, 32'h81);
         push_idle(1);
      end
      start8 = 1'b1;
      data8  = 8'h81;
      while (sb.size() > 0) begin
         step();
         e = sb.pop_front();
         tests_run++;
         if ({x8, busy8, done8} !== e) begin
            tests_failed++;
            $display("FAIL back_to_back cycle %0d: got %b%b%b required %b",
                     n, x8, busy8, done8, e);
         end
         n++;
      end
      start8 = 1'b0;
      step();
      tests_run++;
      if ({x8, busy8, done8} !== 3'b000) begin
         tests_failed++;
         $display("FAIL b2b_release: got %b%b%b required 000", x8, busy8, done8);
      end
   endtask

   task automatic test_width4();
      exp_t e;
      int   n = 0;
      start4 = 1'b1;
      data4  = 4'b1001;
      push_frame(4, 32'h9);
      push_idle(2);
      while (sb.size() > 0) begin
         step();
         e = sb.pop_front();
         tests_run++;
         if ({x4, busy4, done4} !== e) begin
            tests_failed++;
            $display("FAIL width4 cycle %0d: got %b%b%b required %b",
                     n, x4, busy4, done4, e);
         end
         if (n == 0) start4 = 1'b0;
         n++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_preamble();
      test_abort();
      test_ignore_start();
      test_back_to_back();
      test_width4();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
